// File: rtl/ifft_common_if.sv
// Stream bundle for the inverse FFT: bins in on s_*, time samples out on m_*.
// The slave modport is the transform's view; master is the producer/consumer side.
interface ifft_common_if #(
   parameter int DW = 32
);
   logic                 s_valid;
   logic                 s_ready;
   logic signed [DW-1:0] s_r;
   logic signed [DW-1:0] s_i;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [DW-1:0] m_r;
   logic signed [DW-1:0] m_i;
   logic                 m_last;

   modport slave (
      input  s_valid, s_r, s_i, m_ready,
      output s_ready, m_valid, m_r, m_i, m_last
   );

   modport master (
      output s_valid, s_r, s_i, m_ready,
      input  s_ready, m_valid, m_r, m_i, m_last
   );
endinterface

// File: rtl/ifft_common.sv
// Iterative in-place radix-2 DIT inverse FFT, one butterfly per cycle, with a
// divide-by-2 at every stage so the overall gain is 1/N.
module ifft_common #(
   parameter int N  = 8,
   parameter int DW = 32,
   parameter int TW = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   ifft_common_if.slave   io,
   output logic           busy
);
   localparam int  LG = $clog2(N);
   localparam int  PW = DW + TW + 1;
   localparam real PI = 3.14159265358979323846;

   typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;

   state_t              state, state_nx;
   logic [LG-1:0]       cnt, cnt_nx;
   logic [LG-1:0]       stage, stage_nx;
   logic signed [DW-1:0] mem_r [N];
   logic signed [DW-1:0] mem_i [N];

   logic signed [TW-1:0] tw_r [N/2];
   logic signed [TW-1:0] tw_i [N/2];

   function automatic logic signed [TW-1:0] tw_round(input real x);
      real y;
      y = x * (2.0 ** (TW - 2));
      return TW'($rtoi(y >= 0.0 ? y + 0.5 : y - 0.5));
   endfunction

   function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] x);
      logic [LG-1:0] r;
      for (int b = 0; b < LG; b++) r[b] = x[LG-1-b];
      return r;
   endfunction

   // Drop TW-2 fraction bits (floor) and keep DW+1 bits of the product sum.
   function automatic logic signed [DW:0] scale_prod(input logic signed [PW-1:0] p);
      return p[DW+TW-2:TW-2];
   endfunction

   function automatic logic signed [DW-1:0] halve(input logic signed [DW:0] x);
      return x[DW:1];
   endfunction

   // Conjugate twiddles (positive sine) turn the forward butterfly into the inverse.
   for (genvar g = 0; g < N/2; g++) begin : g_tw
      localparam real ANG = 2.0 * PI * real'(g) / real'(N);
      localparam logic signed [TW-1:0] WR = tw_round($cos(ANG));
      localparam logic signed [TW-1:0] WI = tw_round($sin(ANG));
      assign tw_r[g] = WR;
      assign tw_i[g] = WI;
   end

   int                   s_n, j_n, half, top_n, bot_n, k_n;
   logic [LG-1:0]        top, bot;
   logic [LG-2:0]        tk;
   logic signed [DW-1:0] ar, ai, br, bi;
   logic signed [TW-1:0] wr, wi;
   logic signed [PW-1:0] pr, pi;
   logic signed [DW:0]   tr, ti, sum_r, sum_i, dif_r, dif_i;
   logic signed [DW-1:0] xr, xi, yr, yi;

   always_comb begin
      s_n   = int'(stage);
      j_n   = int'(cnt);
      half  = 1 << s_n;
      top_n = ((j_n >> s_n) << (s_n + 1)) + (j_n & (half - 1));
      bot_n = top_n + half;
      k_n   = (j_n & (half - 1)) << (LG - 1 - s_n);
      top   = LG'(top_n);
      bot   = LG'(bot_n);
      tk    = (LG-1)'(k_n);
   end

   always_comb begin
      ar    = mem_r[top];
      ai    = mem_i[top];
      br    = mem_r[bot];
      bi    = mem_i[bot];
      wr    = tw_r[tk];
      wi    = tw_i[tk];
      pr    = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
      pi    = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
      tr    = scale_prod(pr);
      ti    = scale_prod(pi);
      sum_r = (DW+1)'(ar) + tr;
      sum_i = (DW+1)'(ai) + ti;
      dif_r = (DW+1)'(ar) - tr;
      dif_i = (DW+1)'(ai) - ti;
      xr    = halve(sum_r);
      xi    = halve(sum_i);
      yr    = halve(dif_r);
      yi    = halve(dif_i);
   end

   // Buffer: bit-reversed load, then two write-backs per butterfly cycle.
   always_ff @(posedge clk) begin
      if (state == LOAD && io.s_valid) begin
         mem_r[bitrev(cnt)] <= io.s_r;
         mem_i[bitrev(cnt)] <= io.s_i;
      end else if (state == CALC) begin
         mem_r[top] <= xr;
         mem_i[top] <= xi;
         mem_r[bot] <= yr;
         mem_i[bot] <= yi;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= LOAD;
         cnt   <= '0;
         stage <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         stage <= stage_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      stage_nx = stage;
      case (state)
         LOAD: begin
            if (io.s_valid) begin
               if (cnt == LG'(N - 1)) begin
                  state_nx = CALC;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + LG'(1);
               end
            end
         end
         CALC: begin
            if (cnt == LG'(N/2 - 1)) begin
               cnt_nx = '0;
               if (stage == LG'(LG - 1)) begin
                  state_nx = UNLOAD;
                  stage_nx = '0;
               end else begin
                  stage_nx = stage + LG'(1);
               end
            end else begin
               cnt_nx = cnt + LG'(1);
            end
         end
         UNLOAD: begin
            if (io.m_ready) begin
               if (cnt == LG'(N - 1)) begin
                  state_nx = LOAD;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + LG'(1);
               end
            end
         end
         default: state_nx = LOAD;
      endcase
   end

   assign io.s_ready = (state == LOAD);
   assign io.m_valid = (state == UNLOAD);
   assign io.m_last  = (state == UNLOAD) && (cnt == LG'(N - 1));
   assign io.m_r     = (state == UNLOAD) ? mem_r[cnt] : '0;
   assign io.m_i     = (state == UNLOAD) ? mem_i[cnt] : '0;
   assign busy       = (state != LOAD);
endmodule
